// File: rtl/key_event_pkg.sv
// Shared types and sizing helpers for the multi-key event generator.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  localparam int DEFAULT_CLK_HZ = 100_000_000;
  localparam int MS_DIV         = DEFAULT_CLK_HZ / 1000;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Width able to hold 0..max_count, never narrower than one bit.
  function automatic int cnt_w(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_gen_channel.sv
// One key channel: tick-based debounce followed by the press/long/repeat FSM.
// state  | meaning
// IDLE   | key released, no hold timing running
// HOLD   | key pressed, counting ticks towards long_press
// REPEAT | long_press issued, counting ticks between repeat pulses
module key_channel
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sample,
  output logic key_level,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt
);

  localparam int DW = cnt_w(DEBOUNCE_MS);
  localparam int HW = cnt_w(max2(LONG_MS, REPEAT_MS));
  localparam logic [DW-1:0] D_TC = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] L_TC = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] R_TC = HW'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);

  logic            stable;
  logic            stable_nx;
  logic            accept;
  logic            rise;
  logic            fall;
  logic [DW-1:0]   dcnt;
  logic [HW-1:0]   hcnt;
  key_state_e      state;

  // FSM reacts to the level that stable is about to take, so a release
  // accepted on a tick suppresses any long/repeat due on that same tick.
  assign accept    = tick && (sample != stable) && (dcnt == D_TC);
  assign stable_nx = accept ? sample : stable;
  assign rise      = stable_nx & ~stable;
  assign fall      = ~stable_nx & stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable      <= 1'b0;
      dcnt        <= '0;
      hcnt        <= '0;
      state       <= IDLE;
      key_level   <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
    end else begin
      key_level   <= stable;
      press       <= stable & ~key_level;
      release_evt <= ~stable & key_level;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      stable      <= stable_nx;

      if (sample == stable) begin
        dcnt <= '0;
      end else if (tick) begin
        dcnt <= (dcnt == D_TC) ? '0 : dcnt + 1'b1;
      end

      if (fall) begin
        state <= IDLE;
        hcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= HOLD;
              hcnt  <= '0;
            end
          end
          HOLD: begin
            if (tick) begin
              if (hcnt == L_TC) begin
                long_press <= 1'b1;
                state      <= REPEAT;
                hcnt       <= '0;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            if ((REPEAT_MS > 0) && tick) begin
              if (hcnt == R_TC) begin
                repeat_evt <= 1'b1;
                hcnt       <= '0;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            hcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Multi-key front end: shared ms prescaler, per-key synchroniser and channel.
// release/repeat are reserved words, hence the release_evt/repeat_evt names.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] release_evt,
  output logic [NUM_KEYS-1:0] long_press,
  output logic [NUM_KEYS-1:0] repeat_evt
);

  localparam int DIV = ms_div(CLK_HZ);
  localparam int PW  = cnt_w(DIV - 1);
  localparam logic [PW-1:0] P_TC = PW'(DIV - 1);

  logic [PW-1:0]       pcnt;
  logic                tick;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;

  assign tick = (pcnt == P_TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

  // Polarity is folded in before the synchroniser so everything after it is 1 = pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in ^ {NUM_KEYS{(ACTIVE_LOW != 0)}};
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .sample      (sync2[i]),
      .key_level   (key_level[i]),
      .press       (press[i]),
      .release_evt (release_evt[i]),
      .long_press  (long_press[i]),
      .repeat_evt  (repeat_evt[i])
    );
  end

endmodule
